// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared pipeline encodings for the hazard control unit
package hazard_ctrl_unit_pkg;

    // Forwarding mux select for EX operands; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // Wide enough for the full MDU_LAT range of 1..15.
    localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_ctrl_unit_mdu_busy_tracker.sv
// rtl/hazard_ctrl_unit_mdu_busy_tracker.sv - mult/div occupancy down-counter
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   start_i  in   launch pulse, honoured only while idle
//   busy_o   out  registered, high while the counter is non-zero
module mdu_busy_tracker
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic busy_o
);

    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic                 busy_q;

    // A start while the counter is running is dropped rather than reloading.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - MDU_CNT_W'(1);
        end else if (start_i) begin
            cnt_d = MDU_CNT_W'(MDU_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard detection, forwarding and stall accounting
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   rs/rt_iss_hz_i                     issue-stage source registers
//   rs/rt_ex_hz_i, rd_ex_hz_i          EX-stage sources and destination
//   mem_to_reg_ex_hz_i                 EX-stage instruction is a load
//   rd/reg_wr_mem_hz_i, rd/reg_wr_wb_hz_i  MEM / WB writeback destination and enable
//   mdu_start_ex_hz_i, mdu_use_iss_hz_i    mult/div launch, issue-stage HI/LO use
//   branch_taken_ex_hz_i               taken branch resolved in EX
//   stall_fetch/iss_hz_o, flush_iss/ex_hz_o  pipeline control
//   fwd_p1/p2_ex_hz_o                  EX operand forwarding selects
//   mdu_busy_hz_o, stall_cnt_hz_o      MDU occupancy, saturating stall count
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_iss_hz_i,
    input  logic [REG_AW-1:0] rt_iss_hz_i,
    input  logic [REG_AW-1:0] rs_ex_hz_i,
    input  logic [REG_AW-1:0] rt_ex_hz_i,
    input  logic [REG_AW-1:0] rd_ex_hz_i,
    input  logic              mem_to_reg_ex_hz_i,
    input  logic [REG_AW-1:0] rd_mem_hz_i,
    input  logic              reg_wr_mem_hz_i,
    input  logic [REG_AW-1:0] rd_wb_hz_i,
    input  logic              reg_wr_wb_hz_i,
    input  logic              mdu_start_ex_hz_i,
    input  logic              mdu_use_iss_hz_i,
    input  logic              branch_taken_ex_hz_i,
    output logic              stall_fetch_hz_o,
    output logic              stall_iss_hz_o,
    output logic              flush_iss_hz_o,
    output logic              flush_ex_hz_o,
    output logic [1:0]        fwd_p1_ex_hz_o,
    output logic [1:0]        fwd_p2_ex_hz_o,
    output logic              mdu_busy_hz_o,
    output logic [CNT_W-1:0]  stall_cnt_hz_o
);

    // Register 0 is hardwired, so it never forwards; MEM is the younger result.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_mem,
        input logic              wr_mem,
        input logic [REG_AW-1:0] rd_wb,
        input logic              wr_wb
    );
        if (src == '0)                  return FWD_NONE;
        if (wr_mem && (rd_mem == src))  return FWD_MEM;
        if (wr_wb && (rd_wb == src))    return FWD_WB;
        return FWD_NONE;
    endfunction

    fwd_sel_e         fwd_p1, fwd_p2;
    logic             load_use, mdu_hz, mdu_busy, stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mdu_busy_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_busy_tracker (
        .clk     (clk),
        .reset   (reset),
        .start_i (mdu_start_ex_hz_i),
        .busy_o  (mdu_busy)
    );

    always_comb begin
        fwd_p1 = fwd_pick(rs_ex_hz_i, rd_mem_hz_i, reg_wr_mem_hz_i, rd_wb_hz_i, reg_wr_wb_hz_i);
        fwd_p2 = fwd_pick(rt_ex_hz_i, rd_mem_hz_i, reg_wr_mem_hz_i, rd_wb_hz_i, reg_wr_wb_hz_i);
    end

    assign load_use = mem_to_reg_ex_hz_i && (rd_ex_hz_i != '0) &&
                      ((rd_ex_hz_i == rs_iss_hz_i) || (rd_ex_hz_i == rt_iss_hz_i));
    assign mdu_hz   = mdu_busy && mdu_use_iss_hz_i;
    // A taken branch discards the issue-stage instruction, so there is nothing to stall for.
    assign stall    = (load_use || mdu_hz) && !branch_taken_ex_hz_i;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_fetch_hz_o = stall;
    assign stall_iss_hz_o   = stall;
    assign flush_iss_hz_o   = branch_taken_ex_hz_i;
    assign flush_ex_hz_o    = branch_taken_ex_hz_i || load_use || mdu_hz;
    assign fwd_p1_ex_hz_o   = fwd_p1;
    assign fwd_p2_ex_hz_o   = fwd_p2;
    assign mdu_busy_hz_o    = mdu_busy;
    assign stall_cnt_hz_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic       mem_to_reg, reg_wr_mem, reg_wr_wb, mdu_start, mdu_use, branch;

    logic        sf, si, fi, fe, busy;
    logic [1:0]  fwd1, fwd2;
    logic [15:0] cnt;
    logic        sf2, si2, fi2, fe2, busy2;
    logic [1:0]  fwd1b, fwd2b;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        int          f;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .reset(reset),
        .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
        .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
        .mem_to_reg_ex_hz_i(mem_to_reg),
        .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem),
        .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
        .mdu_start_ex_hz_i(mdu_start), .mdu_use_iss_hz_i(mdu_use),
        .branch_taken_ex_hz_i(branch),
        .stall_fetch_hz_o(sf), .stall_iss_hz_o(si),
        .flush_iss_hz_o(fi), .flush_ex_hz_o(fe),
        .fwd_p1_ex_hz_o(fwd1), .fwd_p2_ex_hz_o(fwd2),
        .mdu_busy_hz_o(busy), .stall_cnt_hz_o(cnt)
    );

    hazard_ctrl_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
        .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
        .mem_to_reg_ex_hz_i(mem_to_reg),
        .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem),
        .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
        .mdu_start_ex_hz_i(mdu_start), .mdu_use_iss_hz_i(mdu_use),
        .branch_taken_ex_hz_i(branch),
        .stall_fetch_hz_o(sf2), .stall_iss_hz_o(si2),
        .flush_iss_hz_o(fi2), .flush_ex_hz_o(fe2),
        .fwd_p1_ex_hz_o(fwd1b), .fwd_p2_ex_hz_o(fwd2b),
        .mdu_busy_hz_o(busy2), .stall_cnt_hz_o(cnt2)
    );

    function automatic logic [15:0] fld(input int k);
        case (k)
            0:       return {15'd0, sf};
            1:       return {15'd0, si};
            2:       return {15'd0, fi};
            3:       return {15'd0, fe};
            4:       return {14'd0, fwd1};
            5:       return {14'd0, fwd2};
            6:       return {15'd0, busy};
            7:       return cnt;
            default: return {14'd0, cnt2};
        endcase
    endfunction

    task automatic push(input string n, input int f, input logic [15:0] v);
        exp_t e;
        e.name = n; e.f = f; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        rs_iss = '0; rt_iss = '0; rs_ex = '0; rt_ex = '0; rd_ex = '0;
        rd_mem = '0; rd_wb = '0; mem_to_reg = 0; reg_wr_mem = 0; reg_wr_wb = 0;
        mdu_start = 0; mdu_use = 0; branch = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        push("rst_busy", 6, 0); push("rst_cnt", 7, 0); push("rst_cnt2", 8, 0);
        push("rst_sf", 0, 0); push("rst_fe", 3, 0); push("rst_fwd1", 4, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        mem_to_reg = 1; rd_ex = 5'd6; rs_iss = 5'd6;
        push("rst_lu_sf", 0, 1); push("rst_lu_si", 1, 1); push("rst_lu_fe", 3, 1); push("rst_lu_fi", 2, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
        push("rst_hold_cnt", 7, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [4:0] step_rs[4]  = '{5'd3, 5'd3, 5'd0, 5'd7};
        logic [4:0] step_rt[4]  = '{5'd7, 5'd3, 5'd0, 5'd7};
        logic [4:0] step_mem[4] = '{5'd3, 5'd3, 5'd0, 5'd7};
        logic       step_wm[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] step_wb[4]  = '{5'd3, 5'd3, 5'd0, 5'd7};
        logic       step_ww[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp1[4]     = '{2'b10, 2'b01, 2'b00, 2'b10};
        logic [1:0] exp2[4]     = '{2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            rs_ex = step_rs[i]; rt_ex = step_rt[i];
            rd_mem = step_mem[i]; reg_wr_mem = step_wm[i];
            rd_wb = step_wb[i]; reg_wr_wb = step_ww[i];
            push($sformatf("fwd1_%0d", i), 4, {14'd0, exp1[i]});
            push($sformatf("fwd2_%0d", i), 5, {14'd0, exp2[i]});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_checks++;
                if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        exp_t e;
        pulse_reset();
        mem_to_reg = 1; rd_ex = 5'd5; rt_iss = 5'd5;
        push("lu_sf", 0, 1); push("lu_si", 1, 1); push("lu_fe", 3, 1); push("lu_fi", 2, 0); push("lu_cnt0", 7, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        mem_to_reg = 1; rd_ex = 5'd0; rs_iss = 5'd0; rt_iss = 5'd0;
        push("lu_r0_sf", 0, 0); push("lu_r0_fe", 3, 0); push("lu_cnt1", 7, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        mem_to_reg = 0; rd_ex = 5'd9; rs_iss = 5'd9;
        push("nonload_sf", 0, 0); push("lu_cnt1b", 7, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        mem_to_reg = 1; rd_ex = 5'd9; rs_iss = 5'd9; rt_iss = 5'd2;
        push("lu_rs_sf", 0, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
        push("lu_cnt2", 7, 2);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_mdu();
        exp_t e;
        logic        exp_busy[7] = '{0, 1, 1, 1, 1, 0, 0};
        logic [15:0] exp_cnt[7]  = '{0, 0, 1, 2, 3, 4, 4};
        pulse_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            clear_inputs();
            mdu_start = (c == 0) || (c == 2);
            mdu_use   = 1'b1;
            // load-use on top of the MDU stall must still count once
            if (c == 3) begin mem_to_reg = 1; rd_ex = 5'd4; rs_iss = 5'd4; end
            push($sformatf("mdu_busy_c%0d", c), 6, {15'd0, exp_busy[c]});
            push($sformatf("mdu_sf_c%0d", c), 0, {15'd0, exp_busy[c]});
            push($sformatf("mdu_fe_c%0d", c), 3, {15'd0, exp_busy[c]});
            push($sformatf("mdu_cnt_c%0d", c), 7, exp_cnt[c]);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_checks++;
                if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        exp_t e;
        pulse_reset();
        mem_to_reg = 1; rd_ex = 5'd5; rt_iss = 5'd5; branch = 1;
        push("br_lu_fi", 2, 1); push("br_lu_fe", 3, 1); push("br_lu_sf", 0, 0); push("br_lu_si", 1, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
        mdu_start = 1;
        push("br_lu_cnt", 7, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        mdu_start = 0; mdu_use = 1; branch = 1;
        push("br_mdu_busy", 6, 1); push("br_mdu_sf", 0, 0); push("br_mdu_fi", 2, 1); push("br_mdu_fe", 3, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        branch = 0;
        push("br_mdu_cnt", 7, 0); push("mdu_nobr_sf", 0, 1); push("mdu_nobr_fi", 2, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
        push("mdu_nobr_cnt", 7, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mdu();
        exp_t e;
        logic        exp_busy[5] = '{0, 1, 1, 0, 0};
        logic        exp_sf[5]   = '{0, 1, 1, 0, 0};
        logic [15:0] exp_cnt[5]  = '{0, 0, 1, 0, 0};
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            mdu_start = (c == 0);
            mdu_use   = 1'b1;
            reset     = (c == 2);
            push($sformatf("rmid_busy_c%0d", c), 6, {15'd0, exp_busy[c]});
            push($sformatf("rmid_sf_c%0d", c), 0, {15'd0, exp_sf[c]});
            push($sformatf("rmid_cnt_c%0d", c), 7, exp_cnt[c]);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_checks++;
                if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
                else n_pass++;
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [15:0] exp_sat[6] = '{0, 1, 2, 3, 3, 3};
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            clear_inputs();
            if (c < 5) begin mem_to_reg = 1; rd_ex = 5'd8; rt_iss = 5'd8; end
            push($sformatf("sat2_c%0d", c), 8, exp_sat[c]);
            push($sformatf("cnt16_c%0d", c), 7, 16'(c));
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_checks++;
                if (fld(e.f) !== e.exp) $display("FAIL %s: got %0h expected %0h", e.name, fld(e.f), e.exp);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_branch();
        test_reset_mid_mdu();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter MDU_LAT, default 4, range 1..15: multiply/divide busy cycles after start.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL use a single clock and a synchronous, active-high reset.
REQ-005 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous active-high reset
- rs_iss_hz_i, rt_iss_hz_i  in  REG_AW  issue-stage source registers
- rs_ex_hz_i, rt_ex_hz_i  in  REG_AW  EX-stage source registers
- rd_ex_hz_i  in  REG_AW  EX-stage destination register
- mem_to_reg_ex_hz_i  in  1  EX-stage instruction is a load
- rd_mem_hz_i  in  REG_AW  MEM-stage destination; reg_wr_mem_hz_i  in  1  its write enable
- rd_wb_hz_i  in  REG_AW  WB-stage destination; reg_wr_wb_hz_i  in  1  its write enable
- mdu_start_ex_hz_i  in  1  EX-stage mult/div launch pulse
- mdu_use_iss_hz_i  in  1  issue-stage instruction reads HI/LO or is a mult/div
- branch_taken_ex_hz_i  in  1  branch/jump resolved taken in EX
- stall_fetch_hz_o, stall_iss_hz_o  out  1  hold PC / hold issue register
- flush_iss_hz_o, flush_ex_hz_o  out  1  bubble the issue / EX register next edge
- fwd_p1_ex_hz_o, fwd_p2_ex_hz_o  out  2  forwarding select for EX operand 1 (rs) / 2 (rt)
- mdu_busy_hz_o  out  1  mult/div unit occupied
- stall_cnt_hz_o  out  CNT_W  saturating count of load-use and MDU stall cycles

Function
REQ-006 Forwarding SHALL be combinational: 2'b10 if reg_wr_mem and rd_mem == source; else 2'b01 if reg_wr_wb and rd_wb == source; else 2'b00; 2'b11 is never driven.
REQ-007 A source register of 0 SHALL always yield 2'b00; MEM SHALL take priority over WB when both match.
REQ-008 Load-use hazard SHALL be mem_to_reg_ex & rd_ex != 0 & (rd_ex == rs_iss | rd_ex == rt_iss); it asserts stall_fetch, stall_iss and flush_ex for that cycle only.
REQ-009 MDU tracker SHALL be a down-counter: start pulse while idle loads MDU_LAT on the next edge; the counter decrements each cycle until 0; mdu_busy_hz_o = (counter != 0), registered.
REQ-010 A start pulse while busy SHALL be ignored; the counter SHALL NOT reload.
REQ-011 MDU hazard SHALL be mdu_busy & mdu_use_iss; it asserts stall_fetch, stall_iss and flush_ex.
REQ-012 branch_taken_ex SHALL assert flush_iss and flush_ex, and SHALL suppress stall_fetch, stall_iss and counting that cycle (branch wins over load-use and MDU).
REQ-013 Load-use and MDU hazards in the same cycle SHALL produce one stall and one count increment.
REQ-014 stall_cnt SHALL increment by 1 on each stall cycle and saturate at all-ones.
REQ-015 All hazard/forward outputs SHALL be combinational from inputs and registered state; no added latency.

Reset
REQ-016 On reset: MDU counter 0, mdu_busy_hz_o 0, stall_cnt_hz_o 0; reset mid-MDU operation SHALL return to idle on that edge.
REQ-017 While reset is high, stall and flush outputs SHALL still follow REQ-008..REQ-012 combinationally; no state SHALL update except to reset values.

Structure
REQ-018 Forwarding encodings FWD_NONE=00, FWD_WB=01, FWD_MEM=10 SHALL live in the shared pipeline package/header.
REQ-019 The MDU counter SHALL be a sub-module, mdu_busy_tracker, parametrised by MDU_LAT.

Verification
REQ-020 rs_ex=3, rd_mem=3 wr, rd_wb=3 wr -> fwd_p1=10; drop MEM write -> 01; rs_ex=0 with rd_mem=0 wr -> 00.
REQ-021 Load in EX rd_ex=5, rt_iss=5 -> one cycle stall_fetch=stall_iss=flush_ex=1, stall_cnt 0->1; rd_ex=0 -> no stall.
REQ-022 MDU_LAT=4, start at cycle 0 -> busy cycles 1-4; mdu_use_iss held -> stalls cycles 1-4, stall_cnt=4; second start at cycle 2 ignored.
REQ-023 Branch taken coincident with load-use -> flush_iss=flush_ex=1, stalls 0, counter unchanged.
REQ-024 Reset asserted at cycle 2 of an MDU op -> busy=0 and stall_cnt=0 next cycle; CNT_W=2 with 5 stall cycles -> counter holds 3.
